// File: rtl/median3x3_core_if.sv
// Stream bundle for median3x3_core: one pixel column in, one filtered pixel out.
// The core drives the out_* side through the slave modport.
interface median3x3_core_if #(
   parameter int PIX_W = 8
);
   logic             in_valid;
   logic [PIX_W-1:0] row_top;
   logic [PIX_W-1:0] row_mid;
   logic [PIX_W-1:0] row_bot;
   logic             out_valid;
   logic [PIX_W-1:0] out_pixel;
   logic             frame_done;

   modport master (
      output in_valid, row_top, row_mid, row_bot,
      input  out_valid, out_pixel, frame_done
   );

   modport slave (
      input  in_valid, row_top, row_mid, row_bot,
      output out_valid, out_pixel, frame_done
   );
endinterface

// File: rtl/median3x3_core.sv
// 3x3 median filter core: column window, 3-stage sorting network, frame-end pulse.
// Optional MEDIAN_NOISE_DETECT_EN: only salt/pepper centres are replaced by the median.
module median3x3_core #(
   parameter int IMG_WIDTH  = 256,
   parameter int IMG_HEIGHT = 256,
   parameter int PIX_W      = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   median3x3_core_if.slave bus
);
   localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   function automatic logic [PIX_W-1:0] max2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      logic [PIX_W-1:0] r;
      if (a > b) r = a;
      else       r = b;
      return r;
   endfunction

   function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      logic [PIX_W-1:0] r;
      if (a < b) r = a;
      else       r = b;
      return r;
   endfunction

   function automatic logic [PIX_W-1:0] med3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                             input logic [PIX_W-1:0] c);
      return max2(min2(a, b), min2(max2(a, b), c));
   endfunction

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [PIX_W-1:0] r_win_top [0:2];
   logic [PIX_W-1:0] r_win_mid [0:2];
   logic [PIX_W-1:0] r_win_bot [0:2];
   logic             r_win_vld;
   logic             r_win_last;

   logic [PIX_W-1:0] w_s1_lo [0:2];
   logic [PIX_W-1:0] w_s1_md [0:2];
   logic [PIX_W-1:0] w_s1_hi [0:2];
   logic [PIX_W-1:0] r_s1_lo [0:2];
   logic [PIX_W-1:0] r_s1_md [0:2];
   logic [PIX_W-1:0] r_s1_hi [0:2];
   logic             r_s1_vld;
   logic             r_s1_last;

   logic [PIX_W-1:0] w_s2_lo_max;
   logic [PIX_W-1:0] w_s2_md_med;
   logic [PIX_W-1:0] w_s2_hi_min;
   logic [PIX_W-1:0] r_s2_lo_max;
   logic [PIX_W-1:0] r_s2_md_med;
   logic [PIX_W-1:0] r_s2_hi_min;
   logic             r_s2_vld;
   logic             r_s2_last;

   logic [PIX_W-1:0] w_s3_pixel;
   logic             r_out_valid;
   logic [PIX_W-1:0] r_out_pixel;
   logic             r_frame_done;

`ifdef MEDIAN_NOISE_DETECT_EN
   logic [PIX_W-1:0] r_s1_ctr;
   logic [PIX_W-1:0] r_s2_ctr;
`endif

   logic w_col_last;
   logic w_row_last;
   logic w_complete;

   assign w_col_last = (r_col == COL_LAST);
   assign w_row_last = (r_row == ROW_LAST);
   assign w_complete = bus.in_valid && (r_col >= COL_W'(2)) && (r_row >= ROW_W'(2));

   // Window shift and column/row tagging of the incoming column; index 2 is the newest column.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col      <= '0;
         r_row      <= '0;
         r_win_vld  <= 1'b0;
         r_win_last <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            r_win_top[i] <= '0;
            r_win_mid[i] <= '0;
            r_win_bot[i] <= '0;
         end
      end else if (bus.in_valid) begin
         r_win_vld  <= w_complete;
         r_win_last <= w_complete && w_col_last && w_row_last;
         for (int i = 0; i < 2; i++) begin
            r_win_top[i] <= r_win_top[i+1];
            r_win_mid[i] <= r_win_mid[i+1];
            r_win_bot[i] <= r_win_bot[i+1];
         end
         r_win_top[2] <= bus.row_top;
         r_win_mid[2] <= bus.row_mid;
         r_win_bot[2] <= bus.row_bot;
         if (w_col_last) begin
            r_col <= '0;
            if (w_row_last) r_row <= '0;
            else            r_row <= r_row + ROW_W'(1);
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end else begin
         r_win_vld  <= 1'b0;
         r_win_last <= 1'b0;
      end
   end

   // S1: sort each window column into lo/mid/hi.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_s1_lo[i] = min2(min2(r_win_top[i], r_win_mid[i]), r_win_bot[i]);
         w_s1_md[i] = med3(r_win_top[i], r_win_mid[i], r_win_bot[i]);
         w_s1_hi[i] = max2(max2(r_win_top[i], r_win_mid[i]), r_win_bot[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_last <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            r_s1_lo[i] <= '0;
            r_s1_md[i] <= '0;
            r_s1_hi[i] <= '0;
         end
`ifdef MEDIAN_NOISE_DETECT_EN
         r_s1_ctr <= '0;
`endif
      end else begin
         r_s1_vld  <= r_win_vld;
         r_s1_last <= r_win_last;
         for (int i = 0; i < 3; i++) begin
            r_s1_lo[i] <= w_s1_lo[i];
            r_s1_md[i] <= w_s1_md[i];
            r_s1_hi[i] <= w_s1_hi[i];
         end
`ifdef MEDIAN_NOISE_DETECT_EN
         r_s1_ctr <= r_win_mid[1];
`endif
      end
   end

   // S2: the median lies between max-of-lows and min-of-highs, so three values remain.
   always_comb begin
      w_s2_lo_max = max2(max2(r_s1_lo[0], r_s1_lo[1]), r_s1_lo[2]);
      w_s2_md_med = med3(r_s1_md[0], r_s1_md[1], r_s1_md[2]);
      w_s2_hi_min = min2(min2(r_s1_hi[0], r_s1_hi[1]), r_s1_hi[2]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_vld    <= 1'b0;
         r_s2_last   <= 1'b0;
         r_s2_lo_max <= '0;
         r_s2_md_med <= '0;
         r_s2_hi_min <= '0;
`ifdef MEDIAN_NOISE_DETECT_EN
         r_s2_ctr    <= '0;
`endif
      end else begin
         r_s2_vld    <= r_s1_vld;
         r_s2_last   <= r_s1_last;
         r_s2_lo_max <= w_s2_lo_max;
         r_s2_md_med <= w_s2_md_med;
         r_s2_hi_min <= w_s2_hi_min;
`ifdef MEDIAN_NOISE_DETECT_EN
         r_s2_ctr    <= r_s1_ctr;
`endif
      end
   end

   // S3: final median, optionally bypassed when the centre is not salt or pepper.
   always_comb begin
`ifdef MEDIAN_NOISE_DETECT_EN
      if ((r_s2_ctr == {PIX_W{1'b0}}) || (r_s2_ctr == {PIX_W{1'b1}})) begin
         w_s3_pixel = med3(r_s2_lo_max, r_s2_md_med, r_s2_hi_min);
      end else begin
         w_s3_pixel = r_s2_ctr;
      end
`else
      w_s3_pixel = med3(r_s2_lo_max, r_s2_md_med, r_s2_hi_min);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_pixel  <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_out_valid  <= r_s2_vld;
         r_frame_done <= r_s2_vld && r_s2_last;
         if (r_s2_vld) r_out_pixel <= w_s3_pixel;
         else          r_out_pixel <= r_out_pixel;
      end
   end

   assign bus.out_valid  = r_out_valid;
   assign bus.out_pixel  = r_out_pixel;
   assign bus.frame_done = r_frame_done;

endmodule

// File: doc/median3x3_core.md
Name: median3x3_core

Overview:
- Downstream consumer of the two line-delay FIFOs in the salt-and-pepper filter datapath.
- Each cycle it accepts one column of three vertically aligned pixels: the current pixel plus the one-line and two-line delayed pixels from the FIFOs.
- It assembles a 3x3 window and computes the median in a fixed-latency pipelined sorting network. It emits the filtered pixel for the window centre, plus a frame-end pulse.

Parameters:
- IMG_WIDTH, 256, pixels per line; must be >= 3.
- IMG_HEIGHT, 256, lines per frame; must be >= 3.
- PIX_W, 8, bits per pixel.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  column present this cycle.
- row_top  input  PIX_W  pixel two lines above current (oldest FIFO tap).
- row_mid  input  PIX_W  pixel one line above current (first FIFO tap).
- row_bot  input  PIX_W  current incoming pixel.
- out_valid  output  1  out_pixel valid this cycle.
- out_pixel  output  PIX_W  filtered centre pixel.
- frame_done  output  1  one-cycle pulse, coincident with the last out_valid of a frame.

Behaviour:
- Reset: rst_n is asynchronous and active-low. On assertion, all registers clear immediately: window, column/row counters, pipeline data and valid bits. Outputs are out_valid=0, out_pixel=0, frame_done=0.
- Reset mid-frame discards all in-flight data. After release, the next in_valid is treated as column 0, row 0.
- Counters:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1, both tagging the incoming column.
  - They advance only on in_valid.
  - col wraps to 0 after IMG_WIDTH-1 and increments row.
  - row wraps to 0 after IMG_HEIGHT-1 together with col. This is the end of frame.
- Window:
  - On in_valid, three 3-deep column shift registers shift by one; the new column enters the rightmost position.
  - No shift without in_valid; the window holds.
- Window-complete condition: in_valid with col >= 2 and row >= 2. Border pixels produce no output.
- Per-frame output count: exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- Pipeline: advances every cycle, with no backpressure. A bubble propagates as valid=0.
  - S1: sort each of the three window columns into (lo, mid, hi).
  - S2: compute max of the three lo values, median of the three mid values, min of the three hi values.
  - S3: median of the three S2 results becomes out_pixel. Centre pixel and last flag travel alongside.
- Latency: out_valid asserts exactly 3 cycles after the in_valid edge that completed the window.
- out_pixel corresponds to centre coordinate (row-1, col-1) of the completing column.
- out_pixel holds its last value when out_valid=0.
- frame_done:
  - The last flag is set for the window completed at col=IMG_WIDTH-1 and row=IMG_HEIGHT-1.
  - frame_done pulses with that window's out_valid.
  - The next frame may start the cycle after the wrap, with no idle cycles required.
- Line wrap: columns 0 and 1 of a new line never complete a window. Stale left-hand columns from the previous line are therefore never emitted.
- Comparisons are unsigned PIX_W-bit. Ties are resolved by any stable ordering, since the median value is unaffected.
- Gaps of any length between in_valid pulses are legal. The output is identical to gapless input, only shifted in time.

Optional Feature:
- Macro: MEDIAN_NOISE_DETECT_EN.
- Defined:
  - S3 checks the pipelined centre pixel.
  - If the centre equals 0 or 2^PIX_W-1 (pepper/salt), out_pixel is the median.
  - Otherwise out_pixel is the unmodified centre pixel.
  - Latency is unchanged.
- Undefined: out_pixel is always the median. The centre pixel is not carried through the pipeline.

Test Plan:
- Reset state: hold rst_n=0 for 5 cycles while driving in_valid=1 -> out_valid=0, out_pixel=0, frame_done=0 throughout. Deassert, then feed a 256x256 frame -> first out_valid exactly 3 cycles after the column at col=2, row=2.
- Constant frame: all pixels 100 -> exactly 64516 out_valid pulses, each out_pixel=100. frame_done is high only on the 64516th.
- Salt outlier: constant 50 with a single 255 at (10,10) -> output for centre (10,10) is 50. Undefined build: all outputs 50. Defined build: non-noisy centres also pass through as 50.
- Defined-build passthrough: constant 50 with centre (20,20)=120 and its 8 neighbours 50 -> output 120 with MEDIAN_NOISE_DETECT_EN defined, 50 without.
- Gapped input: in_valid toggling 1,0,0,1 pattern on a ramp image (pixel = col) -> output sequence identical to gapless run. Interior outputs equal the centre column index.
- Mid-frame reset: assert rst_n=0 for 1 cycle at row 100 -> pipeline flushes with no out_valid in the following 3 cycles. A fresh full frame afterwards yields 64516 outputs and one frame_done.
